// File: rtl/uart_frame_packer.sv
// Assembles framed UART bytes (A5, addr, payload, XOR checksum) into one wide
// BRAM word and writes it through port A once the softmax core releases the memory.
module uart_frame_packer #(
  parameter int WORD_W      = 1028,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_done,
  input  logic [7:0]        i_rxd,
  input  logic              i_core_busy,
  output logic              o_mem_cena,
  output logic              o_mem_wea,
  output logic [ADDR_W-1:0] o_mem_addra,
  output logic [WORD_W-1:0] o_mem_dina,
  output logic              o_frame_ok,
  output logic              o_frame_err,
  output logic [1:0]        o_err_code,
  output logic              o_busy
);

  localparam int NB    = (WORD_W + 7) / 8;
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       HEADER   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TO_W-1:0]    idle_q, idle_d;
  logic [7:0]         acc_q, acc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WORD_W-1:0]  payload_q, payload_d;
  logic               cena_q, cena_d;
  logic               wea_q, wea_d;
  logic               ok_q, ok_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               busy_q, busy_d;
  logic               timed;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    payload_d = payload_q;
    cena_d    = 1'b0;
    wea_d     = 1'b0;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    code_d    = code_q;
    timed     = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);

    // A byte landing on the timeout cycle wins over the timeout.
    if (!timed) begin
      idle_d = '0;
    end else if (i_rx_done) begin
      idle_d = '0;
    end else if (idle_q == TO_LAST) begin
      idle_d  = '0;
      err_d   = 1'b1;
      code_d  = 2'd2;
      state_d = IDLE;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_rx_done && (i_rxd == HEADER)) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (i_rx_done) begin
          addr_d  = ADDR_W'(i_rxd);
          acc_d   = i_rxd;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (i_rx_done) begin
          acc_d = acc_q ^ i_rxd;
          // Bits of the last byte beyond WORD_W-1 simply have no home.
          for (int i = 0; i < WORD_W; i++) begin
            if ((i / 8) == int'(cnt_q)) begin
              payload_d[IDX_W'(i)] = i_rxd[3'(i)];
            end
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = CSUM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (i_rx_done) begin
          if (i_rxd == acc_q) begin
            state_d = WRITE;
          end else begin
            err_d   = 1'b1;
            code_d  = 2'd1;
            state_d = IDLE;
          end
        end
      end
      WRITE: begin
        if (!i_core_busy) begin
          cena_d  = 1'b1;
          wea_d   = 1'b1;
          ok_d    = 1'b1;
          code_d  = 2'd0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idle_q    <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      payload_q <= '0;
      cena_q    <= 1'b0;
      wea_q     <= 1'b0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      payload_q <= payload_d;
      cena_q    <= cena_d;
      wea_q     <= wea_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      code_q    <= code_d;
      busy_q    <= busy_d;
    end
  end

  assign o_mem_cena  = cena_q;
  assign o_mem_wea   = wea_q;
  assign o_mem_addra = addr_q;
  assign o_mem_dina  = payload_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = code_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed plus randomized frames against a frame-level reference model
// (expected word, checksum and write/error outcome computed from the byte list).
module tb_uart_frame_packer;

  localparam int WORD_W = 1028;
  localparam int ADDR_W = 8;
  localparam int TO_CYC = 100;
  localparam int NB     = (WORD_W + 7) / 8;

  logic              clk;
  logic              rst_n;
  logic              rx_done;
  logic [7:0]        rxd;
  logic              core_busy;
  logic              mem_cena;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addra;
  logic [WORD_W-1:0] mem_dina;
  logic              frame_ok;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              busy;

  int checks;
  int errors;

  // Monitor-side event counters and last captured write
  int                nWr, nOk, nErr, nBoth;
  logic [ADDR_W-1:0] lastAddr;
  logic [WORD_W-1:0] lastData;

  logic [7:0] pay [NB];

  uart_frame_packer #(
    .WORD_W(WORD_W),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_rx_done(rx_done),
    .i_rxd(rxd),
    .i_core_busy(core_busy),
    .o_mem_cena(mem_cena),
    .o_mem_wea(mem_wea),
    .o_mem_addra(mem_addra),
    .o_mem_dina(mem_dina),
    .o_frame_ok(frame_ok),
    .o_frame_err(frame_err),
    .o_err_code(err_code),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    nWr = 0; nOk = 0; nErr = 0; nBoth = 0;
    lastAddr = '0; lastData = '0;
  end

  always @(negedge clk) begin
    if (mem_cena && mem_wea) begin
      nWr++;
      lastAddr = mem_addra;
      lastData = mem_dina;
    end
    if (frame_ok) nOk++;
    if (frame_err) nErr++;
    if (frame_ok && frame_err) nBoth++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog observed no_finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [WORD_W-1:0] obs,
                             input logic [WORD_W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rx_done strobe carrying b, then gap idle cycles
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_done = 1'b1;
    rxd     = b;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] frameCsum(input logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int k = 0; k < NB; k++) x = x ^ pay[k];
    return x;
  endfunction

  function automatic logic [WORD_W-1:0] frameData();
    logic [NB*8-1:0] pad;
    pad = '0;
    for (int k = 0; k < NB; k++) pad[8*k +: 8] = pay[k];
    return pad[WORD_W-1:0];
  endfunction

  task automatic fillCounting();
    for (int k = 0; k < NB; k++) pay[k] = 8'(k);
  endtask

  task automatic fillRandom();
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
  endtask

  // Full frame; the checksum byte is sent with no trailing gap
  task automatic sendFrame(input logic [7:0] a, input logic [7:0] cs);
    applyStimulus(8'hA5, $urandom_range(0, 2));
    applyStimulus(a, $urandom_range(0, 2));
    for (int k = 0; k < NB; k++) applyStimulus(pay[k], $urandom_range(0, 2));
    applyStimulus(cs, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_cena"}, WORD_W'(mem_cena), '0);
    checkOutput({tag, "_wea"},  WORD_W'(mem_wea), '0);
    checkOutput({tag, "_addr"}, WORD_W'(mem_addra), '0);
    checkOutput({tag, "_dina"}, mem_dina, '0);
    checkOutput({tag, "_ok"},   WORD_W'(frame_ok), '0);
    checkOutput({tag, "_err"},  WORD_W'(frame_err), '0);
    checkOutput({tag, "_code"}, WORD_W'(err_code), '0);
    checkOutput({tag, "_busy"}, WORD_W'(busy), '0);
  endtask

  initial begin
    int wr0, err0, ok0, n;
    logic [7:0] a, cs;
    bit corrupt;

    checks = 0; errors = 0;
    rst_n = 1'b0; rx_done = 1'b0; rxd = 8'h00; core_busy = 1'b0;

    // Reset state, with a header strobe that must be ignored under reset
    repeat (3) @(negedge clk);
    applyStimulus(8'hA5, 0);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_hdr_ignored", WORD_W'(busy), '0);

    // Good frame to 0x07 with payload k->k
    fillCounting();
    wr0 = nWr; err0 = nErr;
    sendFrame(8'h07, frameCsum(8'h07));
    checkOutput("good_no_early_strobe", WORD_W'(mem_cena), '0);
    checkOutput("good_busy_in_write", WORD_W'(busy), WORD_W'(1));
    @(negedge clk);
    checkOutput("good_cena", WORD_W'(mem_cena), WORD_W'(1));
    checkOutput("good_wea", WORD_W'(mem_wea), WORD_W'(1));
    checkOutput("good_ok", WORD_W'(frame_ok), WORD_W'(1));
    checkOutput("good_addr", WORD_W'(mem_addra), WORD_W'(8'h07));
    checkOutput("good_dina", mem_dina, frameData());
    checkOutput("good_dina_lo", WORD_W'(mem_dina[7:0]), '0);
    checkOutput("good_dina_top", WORD_W'(mem_dina[1027:1024]), '0);
    checkOutput("good_code", WORD_W'(err_code), '0);
    @(negedge clk);
    checkOutput("good_strobe_one_cycle", WORD_W'(mem_cena), '0);
    checkOutput("good_idle", WORD_W'(busy), '0);
    repeat (3) @(negedge clk);
    checkOutput("good_write_count", WORD_W'(nWr - wr0), WORD_W'(1));
    checkOutput("good_no_err", WORD_W'(nErr - err0), '0);

    // Bad checksum
    wr0 = nWr; err0 = nErr;
    sendFrame(8'h07, frameCsum(8'h07) ^ 8'h01);
    checkOutput("badcs_err", WORD_W'(frame_err), WORD_W'(1));
    checkOutput("badcs_code", WORD_W'(err_code), WORD_W'(1));
    checkOutput("badcs_idle", WORD_W'(busy), '0);
    repeat (4) @(negedge clk);
    checkOutput("badcs_no_write", WORD_W'(nWr - wr0), '0);
    checkOutput("badcs_err_count", WORD_W'(nErr - err0), WORD_W'(1));

    // Busy hold: core owns BRAM for 50 cycles while bytes keep arriving
    fillRandom();
    a = 8'h3C;
    wr0 = nWr; err0 = nErr;
    core_busy = 1'b1;
    sendFrame(a, frameCsum(a));
    for (int i = 0; i < 10; i++) applyStimulus((i % 2 == 0) ? 8'hA5 : 8'($urandom), 3);
    checkOutput("hold_no_write", WORD_W'(nWr - wr0), '0);
    checkOutput("hold_cena_low", WORD_W'(mem_cena), '0);
    checkOutput("hold_busy", WORD_W'(busy), WORD_W'(1));
    core_busy = 1'b0;
    @(negedge clk);
    checkOutput("hold_cena", WORD_W'(mem_cena), WORD_W'(1));
    checkOutput("hold_ok", WORD_W'(frame_ok), WORD_W'(1));
    checkOutput("hold_addr", WORD_W'(mem_addra), WORD_W'(a));
    checkOutput("hold_dina", mem_dina, frameData());
    repeat (4) @(negedge clk);
    checkOutput("hold_write_count", WORD_W'(nWr - wr0), WORD_W'(1));
    checkOutput("hold_dropped_hdr", WORD_W'(busy), '0);
    checkOutput("hold_no_err", WORD_W'(nErr - err0), '0);

    // Timeout after 10 payload bytes
    wr0 = nWr;
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h11, 1);
    for (int k = 0; k < 10; k++) applyStimulus(8'(k + 1), (k == 9) ? 0 : 1);
    checkOutput("to_no_early_err", WORD_W'(frame_err), '0);
    n = 0;
    while (!frame_err && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_latency", WORD_W'(n), WORD_W'(TO_CYC));
    checkOutput("to_code", WORD_W'(err_code), WORD_W'(2));
    @(negedge clk);
    checkOutput("to_idle", WORD_W'(busy), '0);
    checkOutput("to_no_write", WORD_W'(nWr - wr0), '0);
    fillRandom();
    a = 8'($urandom);
    sendFrame(a, frameCsum(a));
    repeat (3) @(negedge clk);
    checkOutput("to_next_write", WORD_W'(nWr - wr0), WORD_W'(1));
    checkOutput("to_next_addr", WORD_W'(lastAddr), WORD_W'(a));
    checkOutput("to_next_data", lastData, frameData());
    checkOutput("to_next_code", WORD_W'(err_code), '0);

    // Garbage bytes before a good frame to 0xFF
    wr0 = nWr; err0 = nErr;
    applyStimulus(8'h00, 1);
    applyStimulus(8'hFF, 1);
    applyStimulus(8'h5A, 1);
    checkOutput("garbage_idle", WORD_W'(busy), '0);
    fillRandom();
    sendFrame(8'hFF, frameCsum(8'hFF));
    repeat (3) @(negedge clk);
    checkOutput("garbage_no_err", WORD_W'(nErr - err0), '0);
    checkOutput("garbage_write_count", WORD_W'(nWr - wr0), WORD_W'(1));
    checkOutput("garbage_addr", WORD_W'(lastAddr), WORD_W'(8'hFF));
    checkOutput("garbage_data", lastData, frameData());

    // Reset in the middle of the payload
    fillCounting();
    wr0 = nWr; err0 = nErr; ok0 = nOk;
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h33, 0);
    for (int k = 0; k < 60; k++) applyStimulus(pay[k], 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkAllZero("midrst");
    rst_n = 1'b1;
    for (int k = 60; k < NB; k++) applyStimulus(pay[k], 0);
    applyStimulus(frameCsum(8'h33), 0);
    repeat (4) @(negedge clk);
    checkOutput("midrst_no_write", WORD_W'(nWr - wr0), '0);
    checkOutput("midrst_no_err", WORD_W'(nErr - err0), '0);
    checkOutput("midrst_no_ok", WORD_W'(nOk - ok0), '0);
    checkOutput("midrst_idle", WORD_W'(busy), '0);

    // Randomized frames, some with corrupted checksums
    for (int r = 0; r < 6; r++) begin
      fillRandom();
      a = 8'($urandom);
      corrupt = 1'($urandom_range(0, 1));
      cs = frameCsum(a) ^ (corrupt ? 8'($urandom_range(1, 255)) : 8'h00);
      wr0 = nWr; err0 = nErr;
      sendFrame(a, cs);
      repeat (4) @(negedge clk);
      checkOutput("rand_write_count", WORD_W'(nWr - wr0), WORD_W'(!corrupt));
      checkOutput("rand_err_count", WORD_W'(nErr - err0), WORD_W'(corrupt));
      checkOutput("rand_code", WORD_W'(err_code), corrupt ? WORD_W'(1) : '0);
      if (!corrupt) begin
        checkOutput("rand_addr", WORD_W'(lastAddr), WORD_W'(a));
        checkOutput("rand_data", lastData, frameData());
      end
    end

    checkOutput("ok_err_exclusive", WORD_W'(nBoth), '0);
    checkOutput("ok_matches_writes", WORD_W'(nOk), WORD_W'(nWr));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_packer.md
UART_FRAME_PACKER -- requirements
Module: uart_frame_packer

Interface
REQ-001 Parameter WORD_W, default 1028, SHALL set the BRAM word width in bits.
REQ-002 Parameter ADDR_W, default 8, SHALL set the BRAM address width in bits.
REQ-003 Parameter TIMEOUT_CYC, default 100000, SHALL set the maximum number of idle clocks allowed between bytes inside a frame.
REQ-004 The ports SHALL be as follows (clock and reset first):
- i_clk  in  1  sole clock; all logic on its rising edge.
- i_rst  in  1  reset; synchronous, active-low.
- i_rx_done  in  1  one-cycle strobe from uart_rx; i_rxd is valid.
- i_rxd  in  8  received byte.
- i_core_busy  in  1  high = softmax core owns BRAM; writes must wait.
- o_mem_cena  out  1  port-A enable, active-high.
- o_mem_wea  out  1  port-A write enable, active-high.
- o_mem_addra  out  ADDR_W  port-A address.
- o_mem_dina  out  WORD_W  port-A write data.
- o_frame_ok  out  1  one-cycle pulse: good frame written.
- o_frame_err  out  1  one-cycle pulse: frame discarded.
- o_err_code  out  2  cause of last error: 0 none, 1 checksum, 2 timeout; held until next ok/err.
- o_busy  out  1  high in any state other than IDLE.

Function
REQ-005 Frame format SHALL be: header 0xA5, address byte, NB = ceil(WORD_W/8) payload bytes (129 at default), checksum byte.
REQ-006 Payload byte k SHALL be placed in o_mem_dina[8k+7:8k]; bits of the last byte above WORD_W-1 SHALL be discarded.
REQ-007 Checksum SHALL be the 8-bit XOR of the address byte and all payload bytes; the header SHALL be excluded.
REQ-008 The FSM SHALL have states IDLE, ADDR, DATA, CSUM, WRITE; only bytes qualified by i_rx_done SHALL advance it.
REQ-009 IDLE: 0xA5 -> ADDR; any other byte SHALL be ignored silently, with no error pulse.
REQ-010 ADDR: the byte SHALL be latched as the address and the XOR accumulator seeded with it -> DATA.
REQ-011 DATA: a byte counter 0..NB-1 SHALL store each byte and XOR it into the accumulator; after byte NB-1 -> CSUM.
REQ-012 CSUM: on a match -> WRITE; on a mismatch SHALL pulse o_frame_err, set o_err_code=1, and go to IDLE with no memory access.
REQ-013 WRITE: while i_core_busy=1 SHALL wait with o_mem_cena=o_mem_wea=0.
REQ-014 WRITE, first cycle with i_core_busy=0: SHALL assert o_mem_cena=o_mem_wea=1 for exactly one cycle, pulse o_frame_ok in that same cycle, set o_err_code=0, and return to IDLE.
REQ-015 Latency SHALL be one clock from the i_rx_done that carries a matching checksum to the write strobe, plus any i_core_busy wait.
REQ-016 o_mem_addra and o_mem_dina SHALL remain stable from entry into WRITE through the write-strobe cycle.
REQ-017 Bytes arriving in WRITE SHALL be dropped; a 0xA5 arriving in WRITE SHALL NOT start a new frame.
REQ-018 Timeout: in ADDR, DATA or CSUM, an idle counter SHALL reset on each i_rx_done.
REQ-019 When the idle counter reaches TIMEOUT_CYC-1 with no byte, the block SHALL pulse o_frame_err, set o_err_code=2, and go to IDLE.
REQ-020 If i_rx_done coincides with the timeout cycle, the byte SHALL be taken and the timeout SHALL NOT fire.
REQ-021 The idle counter SHALL NOT run in IDLE or WRITE.
REQ-022 o_frame_ok and o_frame_err SHALL never be high in the same cycle.
REQ-023 The payload register SHALL be a single WORD_W-bit buffer; a new frame SHALL overwrite it byte by byte.

Reset
REQ-024 i_rst=0 sampled on a clock edge SHALL force IDLE and clear: byte counter, idle counter, accumulator, o_mem_cena, o_mem_wea, o_mem_addra, o_mem_dina, o_frame_ok, o_frame_err, o_err_code, o_busy.
REQ-025 Reset asserted mid-frame or in WRITE SHALL abort with no write strobe and no ok/err pulse.
REQ-026 i_rx_done while i_rst=0 SHALL be ignored.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Good frame: A5, addr 0x07, payload k->k (k=0..128), correct XOR -> one write at addr 0x07; dina[7:0]=0x00, dina[1027:1024]=0x0 (byte 128=0x80, low nibble 0); o_frame_ok pulse; o_err_code=0.
- Bad checksum: same frame with checksum XOR 0x01 -> o_frame_err; o_err_code=1; no cena/wea.
- Busy hold: good frame with i_core_busy=1 for 50 cycles -> no strobe during those cycles; strobe exactly one cycle after busy falls; bytes sent meanwhile dropped.
- Timeout: TIMEOUT_CYC=100; A5, addr, 10 payload bytes, then silence -> o_frame_err exactly 100 cycles after last i_rx_done; o_err_code=2; next good frame accepted.
- Garbage then frame: bytes 0x00, 0xFF, 0x5A, then good frame to addr 0xFF -> no error pulse; single write at 0xFF.
- Reset mid-DATA: i_rst=0 after 60 payload bytes -> all outputs 0, IDLE; resumed stream without header causes no write.
